// File: rtl/dm_mc_param.sv
// rtl/dm_mc_param.sv - multi-cycle byte-addressable data memory with valid/ready handshake
module dm_mc_param #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;
  logic [7:0]    mem_q [DEPTH];

  logic          accept, enter_resp, err_now;
  logic [ADDR_W:0] addr_ext;
  logic          op_we, op_uns, op_err;
  logic [1:0]    op_size;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   op_wdata;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

  // Reject reserved size, misaligned half/word and addresses beyond the array
  always_comb begin
    addr_ext = {1'b0, req_addr};
    err_now  = 1'b0;
    if (req_size == 2'b11) err_now = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) err_now = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) err_now = 1'b1;
    if (addr_ext >= (ADDR_W+1)'(DEPTH)) err_now = 1'b1;
  end

  // Operation seen at the commit edge: live inputs when LAT=0 commits at accept,
  // otherwise the fields latched at accept
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_uns   = req_unsigned;
      idx0     = req_addr[AW-1:0];
      op_wdata = req_wdata;
      op_err   = err_now;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_uns   = uns_q;
      idx0     = addr_q;
      op_wdata = wdata_q;
      op_err   = err_q;
    end
    // Accesses are aligned when legal, so byte lanes are formed by OR-ing the offset
    idx1 = {idx0[AW-1:1], 1'b1};
    idx2 = {idx0[AW-1:2], 2'b10};
    idx3 = {idx0[AW-1:2], 2'b11};
  end

  // Little-endian load with sign or zero extension
  always_comb begin
    b0 = mem_q[idx0];
    b1 = mem_q[idx1];
    b2 = mem_q[idx2];
    b3 = mem_q[idx3];
    load_val = 32'd0;
    case (op_size)
      2'b00:   load_val = op_uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'b01:   load_val = op_uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      2'b10:   load_val = {b3, b2, b1, b0};
      default: load_val = 32'd0;
    endcase
  end

  // Next-state logic: IDLE -> WAIT (LAT cycles) -> RESP, or IDLE -> RESP when LAT=0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LAT == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LAT);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  // State and wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at accept and response capture at the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= err_now;
        size_q  <= req_size;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q   <= (op_err || op_we) ? 32'd0 : load_val;
        rsp_err_q <= op_err;
      end
    end
  end

  // Storage write on the commit edge; the array itself is never reset
  always_ff @(posedge clk) begin
    if (enter_resp && !op_err && op_we) begin
      case (op_size)
        2'b00: mem_q[idx0] <= op_wdata[7:0];
        2'b01: begin
          mem_q[idx0] <= op_wdata[7:0];
          mem_q[idx1] <= op_wdata[15:8];
        end
        2'b10: begin
          mem_q[idx0] <= op_wdata[7:0];
          mem_q[idx1] <= op_wdata[15:8];
          mem_q[idx2] <= op_wdata[23:16];
          mem_q[idx3] <= op_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_mc_param.sv
// tb/tb_dm_mc_param.sv - directed self-checking bench for dm_mc_param
module tb_dm_mc_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b1;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  dm_mc_param #(.ADDR_W(12), .DEPTH(1024), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dm_mc_param #(.ADDR_W(12), .DEPTH(1024), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat counts edges from the accept edge (inclusive) to rsp_valid
  task automatic xfer(input bit use0, input logic we, input logic [1:0] size, input logic uns,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      output logic [31:0] o_rd, output logic o_er, output int o_lat);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (use0) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_valid0 = 1'b0;
    o_lat = 1;
    while (!(use0 ? rsp_valid0 : rsp_valid) && o_lat < 40) begin
      @(posedge clk);
      #1;
      o_lat++;
    end
    o_rd = use0 ? rsp_rdata0 : rsp_rdata;
    o_er = use0 ? rsp_err0 : rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Word round trip
    xfer(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h80407F01, rd, er, lat);
    chk("st_w_lat", lat, 3);
    chk("st_w_rdata", rd, 32'd0);
    chk("st_w_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, rd, er, lat);
    chk("ld_w_lat", lat, 3);
    chk("ld_w_rdata", rd, 32'h80407F01);
    chk("ld_w_err", {31'd0, er}, 32'd0);

    // Extension
    xfer(0, 1'b0, 2'b00, 1'b0, 12'h013, 32'd0, rd, er, lat);
    chk("ld_b_s", rd, 32'hFFFFFF80);
    xfer(0, 1'b0, 2'b00, 1'b1, 12'h013, 32'd0, rd, er, lat);
    chk("ld_b_u", rd, 32'h00000080);
    xfer(0, 1'b0, 2'b01, 1'b0, 12'h012, 32'd0, rd, er, lat);
    chk("ld_h_s", rd, 32'hFFFF8040);
    xfer(0, 1'b0, 2'b01, 1'b1, 12'h010, 32'd0, rd, er, lat);
    chk("ld_h_u", rd, 32'h00007F01);

    // Partial store
    xfer(0, 1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFFAB, rd, er, lat);
    chk("st_b_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, rd, er, lat);
    chk("ld_after_sb", rd, 32'h8040AB01);

    // Errors
    xfer(0, 1'b0, 2'b01, 1'b0, 12'h011, 32'd0, rd, er, lat);
    chk("err_h_err", {31'd0, er}, 32'd1);
    chk("err_h_rdata", rd, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b0, 12'h012, 32'hDEADBEEF, rd, er, lat);
    chk("err_w_err", {31'd0, er}, 32'd1);
    chk("err_w_rdata", rd, 32'd0);
    xfer(0, 1'b1, 2'b11, 1'b0, 12'h010, 32'h55555555, rd, er, lat);
    chk("err_sz_err", {31'd0, er}, 32'd1);
    chk("err_sz_rdata", rd, 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h400, 32'd0, rd, er, lat);
    chk("err_rng_err", {31'd0, er}, 32'd1);
    chk("err_rng_rdata", rd, 32'd0);
    chk("err_rng_lat", lat, 3);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, rd, er, lat);
    chk("reload_rdata", rd, 32'h8040AB01);
    chk("reload_err", {31'd0, er}, 32'd0);

    // Backpressure with a competing request held on the inputs
    @(negedge clk);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 12'h010;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 12'h012;
    req_we = 1'b1;
    req_wdata = 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h8040AB01);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_no_extra", {31'd0, rsp_valid}, 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, rd, er, lat);
    chk("bp_no_write", rd, 32'h8040AB01);

    // Reset abort of a store in WAIT
    xfer(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'h0BADF00D, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 12'h020; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    xfer(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'd0, rd, er, lat);
    chk("abort_no_commit", rd, 32'h0BADF00D);

    // Zero-latency build
    xfer(1, 1'b1, 2'b10, 1'b0, 12'h040, 32'hCAFE1234, rd, er, lat);
    chk("lat0_st_lat", lat, 1);
    chk("lat0_st_err", {31'd0, er}, 32'd0);
    xfer(1, 1'b0, 2'b10, 1'b0, 12'h040, 32'd0, rd, er, lat);
    chk("lat0_ld_lat", lat, 1);
    chk("lat0_ld_rdata", rd, 32'hCAFE1234);
    xfer(1, 1'b0, 2'b01, 1'b0, 12'h042, 32'd0, rd, er, lat);
    chk("lat0_ld_h_s", rd, 32'hFFFFCAFE);
    xfer(1, 1'b0, 2'b00, 1'b0, 12'h400, 32'd0, rd, er, lat);
    chk("lat0_err", {31'd0, er}, 32'd1);
    chk("lat0_err_rdata", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_mc_param.md
Name: dm_mc_param

Overview:
- Parametrised, multi-cycle, byte-addressable data memory for the processor's memory stage.
- Successor to the single-cycle 4 KB data memory.
- Adds:
  - byte, halfword and word access with sign or zero extension on loads;
  - a valid/ready request and response handshake;
  - configurable access latency (wait states);
  - detection of misaligned and out-of-range accesses, with an error response.
- Storage is little-endian.

Parameters:
- ADDR_W, 12, byte-address width.
- DEPTH, 1024, storage size in bytes. Must be a power of 2, a multiple of 4, and ≤ 2^ADDR_W.
- LAT, 2, wait-state cycles between request accept and response. Legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits.
- rsp_err  out  1  access was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; wait counter clears.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - req_ready is forced to 0 while rst_n is low.
  - The storage array is not reset; its contents survive reset and power up undefined.
- req_ready = 1 exactly when state is IDLE and rst_n is high (combinational).
- State machine, states IDLE, WAIT, RESP:
  - IDLE: on req_valid & req_ready, latch we, size, unsigned, addr and wdata, and evaluate the error condition. Go to WAIT with counter = LAT; if LAT = 0, go directly to RESP.
  - WAIT: decrement the counter each cycle. At the edge where the counter is 1, go to RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready; then return to IDLE.
- Latency and throughput:
  - rsp_valid rises exactly LAT+1 cycles after the accept edge.
  - Only one request is outstanding at a time.
  - Minimum spacing between accepts is LAT+2 cycles when rsp_ready is held high.
  - Inputs are ignored whenever a request is not being accepted.
- Access commit: the memory write (or the read sample into rsp_rdata) happens on the edge that enters RESP, and only if there is no error.
- Error condition:
  - Any of: size = 11; halfword with addr[0] ≠ 0; word with addr[1:0] ≠ 0; addr ≥ DEPTH.
  - On error: no memory write, rsp_rdata = 0, rsp_err = 1.
- Stores:
  - Byte stores write wdata[7:0] to addr.
  - Halfword stores write wdata[15:0] to addr and addr+1.
  - Word stores write all 4 bytes, low byte at addr.
  - rsp_rdata = 0 for stores.
- Loads:
  - Byte: mem[addr], extended from bit 7.
  - Halfword: {mem[addr+1], mem[addr]}, extended from bit 15.
  - Word: 4 bytes as stored; no extension applies.
- Reset mid-operation: a request in WAIT or RESP is discarded with no response. A store still in WAIT is not committed.
- Backpressure: while in RESP with rsp_ready low, all outputs hold and req_ready stays 0.

Test Plan:
- Reset:
  - Hold rst_n low for 3 cycles → req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Release rst_n → req_ready = 1 in the same cycle.
- Word round-trip, LAT = 2:
  - Store word 0x80407F01 at 0x010, then load word 0x010 → rsp_valid exactly 3 cycles after accept, rdata = 0x80407F01, err = 0.
- Extension:
  - Load byte 0x013 signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Load half 0x012 signed → 0xFFFF8040.
  - Load half 0x010 unsigned → 0x00007F01.
- Partial store:
  - Store byte 0xAB (wdata = 0xFFFFFFAB) at 0x011, then load word 0x010 → 0x8040AB01.
- Errors:
  - Each of: half at 0x011; word at 0x012; size = 11; word at 0x400 → rsp_err = 1, rdata = 0.
  - Reload word 0x010 afterwards → still 0x8040AB01.
- Backpressure, reset abort and zero latency:
  - Hold rsp_ready low for 5 cycles → rsp_valid, rdata and err stay stable; req_ready = 0; a concurrent req_valid is not accepted.
  - Pulse rst_n low during WAIT of a store of 0x12345678 to 0x020 → no response, and a later load of 0x020 returns its prior value.
  - Build with LAT = 0 → response 1 cycle after accept.
